// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and helpers for the write-back port arbiter and the
// register file it feeds.
package wb_port_arbiter_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam int          XLEN       = 32;
    localparam logic [4:0]  X0_IDX     = 5'd0;
    localparam logic [31:0] RESET_SP   = 32'h0000_8000;

    // Source that owns the register-file write slot in a given cycle.
    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LQ   = 2'd2
    } wb_src_e;

    // One-hot register mask; x0 never gets a bit so it can never be pending.
    function automatic logic [31:0] reg_bit(input logic [REG_ADDR_W-1:0] r);
        logic [31:0] m;
        m = 32'd1 << r;
        m[X0_IDX] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Result-stream handshakes into the write-back arbiter: the in-order ALU path
// and the load-return path from data memory.
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_ready;

    logic                  ld_valid;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic                  ld_ready;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready
    );
endinterface

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO buffering returned load results until the write port is free.
// Storage is not reset; only pointers and occupancy are.
module wb_load_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Owns the register-file write port: arbitrates ALU results against buffered
// load returns and tracks which registers still await a load.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 4,
    parameter int LQ_AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    wb_port_arbiter_if.slave      bus,
    input  logic                  issue_en,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] pq_addr1,
    input  logic [REG_ADDR_W-1:0] pq_addr2,
    output logic                  pq_hit1,
    output logic                  pq_hit2,
    output logic                  rf_write_en,
    output logic [REG_ADDR_W-1:0] rf_write_addr,
    output logic [XLEN-1:0]       rf_write_value,
    output logic [LQ_AW:0]        lq_count
);
    localparam int LQ_W = REG_ADDR_W + XLEN;

    logic                  lq_push;
    logic                  lq_pop;
    logic                  lq_full;
    logic                  lq_empty;
    logic [LQ_W-1:0]       lq_head;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;

    wb_src_e               src;
    logic [REG_ADDR_W-1:0] win_rd;
    logic [XLEN-1:0]       win_data;

    logic                  wr_en_p1;
    logic [REG_ADDR_W-1:0] wr_addr_p1;
    logic [XLEN-1:0]       wr_val_p1;

    logic [31:0]           pending;
    logic [31:0]           set_mask;
    logic [31:0]           clr_mask;

    // No pass-through when full: the head must drain before anything enters.
    assign lq_push      = bus.ld_valid && !lq_full;
    assign bus.ld_ready = !lq_full;
    assign head_rd      = lq_head[LQ_W-1 -: REG_ADDR_W];
    assign head_data    = lq_head[XLEN-1:0];

    wb_load_fifo #(
        .WIDTH (LQ_W),
        .DEPTH (LQ_DEPTH),
        .AW    (LQ_AW)
    ) u_lq (
        .clk   (clk),
        .reset (reset),
        .push  (lq_push),
        .wdata ({bus.ld_rd, bus.ld_data}),
        .pop   (lq_pop),
        .rdata (lq_head),
        .count (lq_count),
        .full  (lq_full),
        .empty (lq_empty)
    );

    // A full queue preempts the ALU so memory returns can never deadlock.
    always_comb begin
        src      = WB_IDLE;
        win_rd   = head_rd;
        win_data = head_data;
        if (lq_full) begin
            src = WB_LQ;
        end else if (bus.alu_valid) begin
            src      = WB_ALU;
            win_rd   = bus.alu_rd;
            win_data = bus.alu_data;
        end else if (!lq_empty) begin
            src = WB_LQ;
        end
    end

    assign lq_pop        = (src == WB_LQ);
    assign bus.alu_ready = (src == WB_ALU);

    // ---- stage p1: registered register-file write ----
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_val_p1  <= '0;
        end else if (src != WB_IDLE) begin
            wr_en_p1   <= (win_rd != X0_IDX);
            wr_addr_p1 <= win_rd;
            wr_val_p1  <= win_data;
        end else begin
            wr_en_p1   <= 1'b0;
        end
    end

    assign rf_write_en    = wr_en_p1;
    assign rf_write_addr  = wr_addr_p1;
    assign rf_write_value = wr_val_p1;

    // Set is applied after clear so a re-issue in the pop cycle stays pending.
    assign set_mask = issue_en ? reg_bit(issue_rd) : '0;
    assign clr_mask = lq_pop   ? reg_bit(head_rd)  : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign pq_hit1 = pending[pq_addr1];
    assign pq_hit2 = pending[pq_addr2];
endmodule
